multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 144 ++++++++++++++
 tb/tb_multicycle_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle RISC-V style control FSM that sequences the
// datapath enables per instruction class and counts retired instructions.
module multicycle_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        adr_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_op,
  output logic [1:0]  imm_src,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] retire_count
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WB = 4'd4,
    S_MEM_WR = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALU_WB = 4'd8,
    S_BEQ    = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd15
  } state_t;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_ALUI = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_retire_count;
  logic        w_retire;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_retire_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retire_count <= r_retire_count + 32'd1;
    end
  end
  // A store retires only on the edge that completes its memory handshake.
  assign w_retire = (r_state == S_MEM_WB) | (r_state == S_ALU_WB) | (r_state == S_BEQ) |
                    ((r_state == S_MEM_WR) & mem_ready);
  assign state = r_state;
  assign retire_count = r_retire_count;
  always_comb begin
    w_next = r_state;
    pc_write = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    adr_src = 1'b0;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    result_src = 2'b00;
    alu_op = 2'b00;
    illegal = 1'b0;
    imm_src = (opcode == OP_STORE) ? 2'b01 : (opcode == OP_BRANCH) ? 2'b10 :
              (opcode == OP_JAL) ? 2'b11 : 2'b00;
    case (r_state)
      S_FETCH: begin
        mem_read = 1'b1;
        alu_src_b = 2'b10;
        result_src = 2'b10;
        ir_write = mem_ready;
        pc_write = mem_ready;
        w_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        w_next = (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEM_ADR :
                 (opcode == OP_R) ? S_EXEC_R : (opcode == OP_ALUI) ? S_EXEC_I :
                 (opcode == OP_BRANCH) ? S_BEQ : (opcode == OP_JAL) ? S_JAL : S_TRAP;
      end
      S_MEM_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        adr_src = 1'b1;
        w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_write = 1'b1;
        w_next = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        adr_src = 1'b1;
        w_next = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op = 2'b10;
        w_next = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op = 2'b10;
        w_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        w_next = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op = 2'b01;
        pc_write = zero;
        w_next = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write = 1'b1;
        w_next = S_ALU_WB;
      end
      S_TRAP: illegal = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-instruction reference sequences feed an expected-output
// queue; a negedge monitor pops and compares every cycle.
module tb_multicycle_controller;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_ALUI = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic pc_write, ir_write, reg_write, mem_read, mem_write, adr_src, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op, imm_src;
  logic [3:0] state;
  logic [31:0] retire_count;
  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] bus;
    logic [31:0] rc;
  } exp_t;
  exp_t q[$];
  exp_t m_e;
  int checks = 0;
  int errors = 0;
  logic [31:0] mdl_rc = '0;
  bit do_preload = 1'b0;
  logic [6:0] ops[6] = '{OP_R, OP_LOAD, OP_ALUI, OP_STORE, OP_BRANCH, OP_JAL};
  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_op(alu_op), .imm_src(imm_src), .state(state), .illegal(illegal),
    .retire_count(retire_count)
  );
  always #5 clk = ~clk;
  function automatic logic [16:0] exp_bus(int st, logic mr, logic z, logic [6:0] op);
    logic pcw, irw, rw, mrd, mwr, adr, ill;
    logic [1:0] sa, sb, rs, ao, im;
    {pcw, irw, rw, mrd, mwr, adr, ill} = '0;
    {sa, sb, rs, ao} = '0;
    im = (op == OP_STORE) ? 2'd1 : (op == OP_BRANCH) ? 2'd2 : (op == OP_JAL) ? 2'd3 : 2'd0;
    case (st)
      0: begin mrd = 1; sb = 2; rs = 2; irw = mr; pcw = mr; end
      1: begin sa = 1; sb = 1; end
      2: begin sa = 2; sb = 1; end
      3: begin mrd = 1; adr = 1; end
      4: begin rs = 1; rw = 1; end
      5: begin mwr = 1; adr = 1; end
      6: begin sa = 2; ao = 2; end
      7: begin sa = 2; sb = 1; ao = 2; end
      8: rw = 1;
      9: begin sa = 2; ao = 1; pcw = z; end
      10: begin sa = 1; sb = 2; pcw = 1; end
      15: ill = 1;
      default: ;
    endcase
    return {pcw, irw, rw, mrd, mwr, adr, sa, sb, rs, ao, im, ill};
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      chk("state", {28'd0, state}, {28'd0, m_e.st});
      chk($sformatf("outputs(st=%0d)", m_e.st),
          {15'd0, pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
           alu_src_a, alu_src_b, result_src, alu_op, imm_src, illegal}, {15'd0, m_e.bus});
      chk("retire_count", retire_count, m_e.rc);
    end
  end
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic step(input int st, input logic [6:0] op, input logic mr, input logic z,
                      input bit retire);
    exp_t e;
    @(posedge clk);
    #1;
    if (do_preload) begin
      dut.r_retire_count = 32'hFFFF_FFFF;
      mdl_rc = 32'hFFFF_FFFF;
      do_preload = 1'b0;
    end
    opcode = op;
    mem_ready = mr;
    zero = z;
    e.st = 4'(st);
    e.bus = exp_bus(st, mr, z, op);
    e.rc = mdl_rc;
    q.push_back(e);
    if (retire) mdl_rc++;
  endtask
  task automatic wait_state(input int st, input logic [6:0] op, input int stall, input bit retire);
    int n;
    n = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
    repeat (n) step(st, op, 1'b0, rb(), 1'b0);
    step(st, op, 1'b1, rb(), retire);
  endtask
  task automatic run_instr(input logic [6:0] op, input logic z, input int stall);
    wait_state(0, op, stall, 1'b0);
    step(1, op, rb(), rb(), 1'b0);
    case (op)
      OP_LOAD: begin
        step(2, op, rb(), rb(), 1'b0);
        wait_state(3, op, stall, 1'b0);
        step(4, op, rb(), rb(), 1'b1);
      end
      OP_STORE: begin
        step(2, op, rb(), rb(), 1'b0);
        wait_state(5, op, stall, 1'b1);
      end
      OP_R: begin
        step(6, op, rb(), rb(), 1'b0);
        step(8, op, rb(), rb(), 1'b1);
      end
      OP_ALUI: begin
        step(7, op, rb(), rb(), 1'b0);
        step(8, op, rb(), rb(), 1'b1);
      end
      OP_BRANCH: step(9, op, rb(), z, 1'b1);
      OP_JAL: begin
        step(10, op, rb(), rb(), 1'b0);
        step(8, op, rb(), rb(), 1'b1);
      end
      default: repeat (10) step(15, op, rb(), rb(), 1'b0);
    endcase
  endtask
  // Reset asserted mid-cycle, away from any clock edge; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("reset_state", {28'd0, state}, 32'd0);
    chk("reset_retire", retire_count, 32'd0);
    mdl_rc = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    #3;
    chk("por_state", {28'd0, state}, 32'd0);
    chk("por_retire", retire_count, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr(OP_R, 1'b0, 0);
    run_instr(OP_LOAD, 1'b0, 3);
    run_instr(OP_BRANCH, 1'b1, 0);
    run_instr(OP_BRANCH, 1'b0, 0);
    for (int i = 0; i < 150; i++) run_instr(ops[$urandom_range(0, 5)], rb(), -1);
    do_preload = 1'b1;
    run_instr(OP_JAL, 1'b0, 0);
    run_instr(OP_ALUI, 1'b0, 1);
    step(0, OP_STORE, 1'b1, 1'b0, 1'b0);
    step(1, OP_STORE, 1'b0, 1'b0, 1'b0);
    step(2, OP_STORE, 1'b0, 1'b0, 1'b0);
    step(5, OP_STORE, 1'b0, 1'b0, 1'b0);
    do_reset();
    run_instr(OP_STORE, 1'b0, 2);
    run_instr(7'b1111111, 1'b0, 0);
    do_reset();
    run_instr(OP_R, 1'b0, 0);
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
